// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: serialises MEM-stage load/store and instruction-fetch
// requests onto a byte-wide unified RAM port and returns the assembled
// word with a one-cycle done pulse per source.
// Optional build macro IO_STALL_EN adds io_buffer_full, which stalls writes
// to the I/O region (address bits 17:16 == 2'b11) while the buffer is full.
module mem_bus_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              d_load,
    input  logic              d_store,
    input  logic [2:0]        d_nbytes,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_done,
`ifdef IO_STALL_EN
    input  logic              io_buffer_full,
`endif
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            r_state, w_next;
    logic [2:0]        r_cnt, r_rcnt, r_n;
    logic [ADDR_W-1:0] r_addr, r_ram_a;
    logic [DATA_W-1:0] r_wdata, r_buf, r_d_rdata, r_if_inst, w_merged;
    logic [7:0]        r_ram_dout;
    logic              r_ram_wr, r_src_if, r_aval, r_dvalid;
    logic              w_req_d, w_accept, w_stall, w_last_rd, w_wr_end;
    logic [2:0]        w_req_n;

    assign w_req_d   = d_store | d_load;
    assign w_req_n   = w_req_d ? ((d_nbytes > 3'd4) ? 3'd4 : d_nbytes) : 3'd4;
    assign w_accept  = (r_state == IDLE) && (w_req_d || if_req);
    assign w_last_rd = (r_state == READ) && r_dvalid && (r_rcnt == r_n - 3'd1);
    assign w_wr_end  = (r_state == WRITE) && !w_stall && (r_cnt == r_n);

`ifdef IO_STALL_EN
    assign w_stall = (r_state == WRITE) && r_ram_wr &&
                     (r_ram_a[17:16] == 2'b11) && io_buffer_full;
`else
    assign w_stall = 1'b0;
`endif

    assign ram_a    = r_ram_a;
    assign ram_dout = r_ram_dout;
    assign ram_wr   = r_ram_wr & rdy & ~w_stall;
    assign d_rdata  = r_d_rdata;
    assign if_inst  = r_if_inst;

    // Current capture buffer with the incoming RAM byte merged into lane rcnt
    always_comb begin
        w_merged = r_buf;
        w_merged[{r_rcnt[1:0], 3'b000} +: 8] = ram_din;
    end

    // Next-state decode and done pulses
    always_comb begin
        w_next  = r_state;
        d_done  = 1'b0;
        if_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_n == 3'd0)
                        w_next = DONE;
                    else if (d_store)
                        w_next = WRITE;
                    else
                        w_next = READ;
                end
            end
            READ:  if (w_last_rd) w_next = DONE;
            WRITE: if (w_wr_end)  w_next = DONE;
            DONE: begin
                w_next  = IDLE;
                d_done  = !r_src_if;
                if_done = r_src_if;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register; rdy low freezes the FSM
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else if (rdy)
            r_state <= w_next;
    end

    // Datapath: byte issue, read capture pipeline and result registers.
    // aval marks a valid read address on ram_a this cycle; dvalid marks the
    // matching byte on ram_din one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rcnt     <= '0;
            r_n        <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_d_rdata  <= '0;
            r_if_inst  <= '0;
            r_ram_a    <= '0;
            r_ram_dout <= '0;
            r_ram_wr   <= 1'b0;
            r_src_if   <= 1'b0;
            r_aval     <= 1'b0;
            r_dvalid   <= 1'b0;
        end else if (rdy) begin
            case (r_state)
                IDLE: begin
                    r_ram_a  <= '0;
                    r_ram_wr <= 1'b0;
                    r_aval   <= 1'b0;
                    r_dvalid <= 1'b0;
                    r_cnt    <= '0;
                    r_rcnt   <= '0;
                    if (w_accept) begin
                        r_addr   <= w_req_d ? d_addr : if_addr;
                        r_n      <= w_req_n;
                        r_wdata  <= d_wdata;
                        r_src_if <= !w_req_d;
                        r_buf    <= '0;
                        if (w_req_n != 3'd0) begin
                            r_ram_a    <= w_req_d ? d_addr : if_addr;
                            r_ram_dout <= d_wdata[7:0];
                            r_ram_wr   <= d_store;
                            r_aval     <= !d_store;
                            r_cnt      <= 3'd1;
                        end else if (!d_store) begin
                            r_d_rdata <= '0;
                        end
                    end
                end
                READ: begin
                    r_dvalid <= r_aval;
                    if (r_cnt < r_n) begin
                        r_ram_a <= r_addr + ADDR_W'(r_cnt);
                        r_cnt   <= r_cnt + 3'd1;
                        r_aval  <= 1'b1;
                    end else begin
                        r_aval <= 1'b0;
                    end
                    if (r_dvalid) begin
                        r_buf  <= w_merged;
                        r_rcnt <= r_rcnt + 3'd1;
                        if (w_last_rd) begin
                            if (r_src_if)
                                r_if_inst <= w_merged;
                            else
                                r_d_rdata <= w_merged;
                        end
                    end
                end
                WRITE: begin
                    if (!w_stall) begin
                        if (r_cnt < r_n) begin
                            r_ram_a    <= r_addr + ADDR_W'(r_cnt);
                            r_ram_dout <= r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                            r_ram_wr   <= 1'b1;
                            r_cnt      <= r_cnt + 3'd1;
                        end else begin
                            r_ram_wr <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_ram_a  <= '0;
                    r_ram_wr <= 1'b0;
                    r_cnt    <= '0;
                    r_rcnt   <= '0;
                    r_aval   <= 1'b0;
                    r_dvalid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl: vector table plus hand-written corner cases,
// with a scoreboard queue of expected completions.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        mem_clr = 1'b1;
    logic        d_load = 1'b0, d_store = 1'b0, if_req = 1'b0;
    logic [2:0]  d_nbytes = 3'd0;
    logic [31:0] d_addr = '0, d_wdata = '0, if_addr = '0;
    logic [31:0] d_rdata, if_inst, ram_a;
    logic        d_done, if_done, ram_wr;
    logic [7:0]  ram_din, ram_dout;
`ifdef IO_STALL_EN
    logic        io_full = 1'b0;
`endif

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        bit          st;
        bit          ld;
        bit          fe;
        logic [2:0]  nb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int unsigned n;
        int unsigned lat;
    } vec_t;

    typedef struct {
        bit          is_if;
        bit          chk;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[18];
    logic [7:0] mem [0:1023];

    mem_bus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .d_load(d_load), .d_store(d_store), .d_nbytes(d_nbytes),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_done(if_done),
`ifdef IO_STALL_EN
        .io_buffer_full(io_full),
`endif
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte RAM, frozen together with the rest of the system by rdy
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (rdy) begin
            ram_din <= mem[ram_a[9:0]];
            if (ram_wr) mem[ram_a[9:0]] <= ram_dout;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Completion monitor: pops the scoreboard on every done pulse
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (d_done || if_done) begin
            chk("done_single_cycle", {31'b0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_source", {31'b0, if_done}, {31'b0, e.is_if});
                chk("done_cycle", cyc, e.cyc);
                if (e.chk) chk("read_data", e.is_if ? if_inst : d_rdata, e.data);
            end
        end
        prev_done = d_done || if_done;
    end

    task automatic clear_req();
        d_store = 1'b0;
        d_load  = 1'b0;
        if_req  = 1'b0;
    endtask

    task automatic wait_done();
        int b = 0;
        while (!(d_done || if_done) && b < 40) begin
            @(negedge clk);
            b++;
        end
        if (b >= 40) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 40 cycles, required a done pulse");
        end
        @(negedge clk);
        chk("idle_ram_a", ram_a, 32'h0);
        chk("idle_ram_wr", {31'b0, ram_wr}, 32'h0);
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned acc;
        @(negedge clk);
        d_store  = v.st;
        d_load   = v.ld;
        if_req   = v.fe;
        d_nbytes = v.nb;
        d_addr   = v.fe ? 32'h3F0 : v.addr;
        if_addr  = v.fe ? v.addr : 32'h3C0;
        d_wdata  = v.wdata;
        acc = cyc + 1;
        sb.push_back('{v.fe, !v.st, v.exp, acc + v.lat});
        if (v.n == 0) begin
            @(negedge clk);
            clear_req();
            chk("nop_ram_wr", {31'b0, ram_wr}, 32'h0);
            chk("nop_ram_a", ram_a, 32'h0);
        end
        for (int unsigned j = 0; j < v.n; j++) begin
            @(negedge clk);
            if (j == 0) clear_req();
            chk("ram_a_seq", ram_a, v.addr + j);
            chk("ram_wr_seq", {31'b0, ram_wr}, {31'b0, v.st});
            if (v.st) chk("ram_dout_seq", {24'b0, ram_dout}, (v.wdata >> (8 * j)) & 32'hFF);
        end
        wait_done();
    endtask

    // 4-byte access with rdy dropped for three cycles after byte 1 is issued
    task automatic rdy_txn(input bit st, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp);
        int unsigned acc;
        @(negedge clk);
        d_store  = st;
        d_load   = !st;
        d_nbytes = 3'd4;
        d_addr   = addr;
        d_wdata  = wd;
        acc = cyc + 1;
        sb.push_back('{1'b0, !st, exp, acc + (st ? 4 : 5) + 3});
        @(negedge clk);
        clear_req();
        chk("stall_ram_a0", ram_a, addr);
        @(negedge clk);
        chk("stall_ram_a1", ram_a, addr + 1);
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold_a", ram_a, addr + 1);
            chk("stall_ram_wr", {31'b0, ram_wr}, 32'h0);
        end
        rdy = 1'b1;
        #1;
        chk("stall_resume_wr", {31'b0, ram_wr}, {31'b0, st});
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned acc;
        vec_t v;

        //           st    ld    fe    nb    addr           wdata          exp            n  lat
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd4, 32'h00000100, 32'h44332211, 32'h00000000, 4, 4};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 3'd4, 32'h00000100, 32'h00000000, 32'h44332211, 4, 5};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'd2, 32'h00000102, 32'h00000000, 32'h00004433, 2, 3};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'd1, 32'h00000103, 32'h00000000, 32'h00000044, 1, 2};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'd1, 32'h00000020, 32'hAABBCCDD, 32'h00000000, 1, 1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'd4, 32'h00000020, 32'h00000000, 32'h000000DD, 4, 5};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'd3, 32'h00000040, 32'h12345678, 32'h00000000, 3, 3};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'd4, 32'h00000040, 32'h00000000, 32'h00345678, 4, 5};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'd7, 32'h00000100, 32'h00000000, 32'h44332211, 4, 5};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 32'h00000100, 32'h00000000, 32'h00000000, 0, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 3'd0, 32'h00000100, 32'h00000000, 32'h44332211, 4, 5};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h00000060, 32'h0000CAFE, 32'h00000000, 2, 2};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 3'd2, 32'h00000060, 32'h00000000, 32'h0000CAFE, 2, 3};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 3'd4, 32'hFFFFFFFE, 32'hD4C3B2A1, 32'h00000000, 4, 4};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 3'd4, 32'hFFFFFFFE, 32'h00000000, 32'hD4C3B2A1, 4, 5};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 3'd4, 32'h00000000, 32'h00000000, 32'h0000D4C3, 4, 5};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h00000080, 32'h00000099, 32'h00000000, 0, 0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 3'd1, 32'h00000080, 32'h00000000, 32'h00000000, 1, 2};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_d_done", {31'b0, d_done}, 32'h0);
        chk("rst_if_done", {31'b0, if_done}, 32'h0);
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_ram_dout", {24'b0, ram_dout}, 32'h0);
        chk("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
        rst = 1'b0;
        mem_clr = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(vecs[i]);

        // Load and fetch requested together: load first, fetch after DONE->IDLE
        @(negedge clk);
        d_load   = 1'b1;
        d_nbytes = 3'd2;
        d_addr   = 32'h40;
        if_req   = 1'b1;
        if_addr  = 32'h100;
        acc = cyc + 1;
        sb.push_back('{1'b0, 1'b1, 32'h00005678, acc + 3});
        sb.push_back('{1'b1, 1'b1, 32'h44332211, acc + 10});
        @(negedge clk);
        d_load = 1'b0;
        repeat (5) @(negedge clk);
        if_req = 1'b0;
        wait_done();

        // rdy held low mid-transfer
        rdy_txn(1'b0, 32'h100, 32'h0, 32'h44332211);
        rdy_txn(1'b1, 32'h300, 32'h0BADF00D, 32'h0);
        v = '{1'b0, 1'b1, 1'b0, 3'd4, 32'h300, 32'h0, 32'h0BADF00D, 4, 5};
        run_vec(v);

`ifdef IO_STALL_EN
        // Byte store to the I/O region while the I/O buffer is full
        @(negedge clk);
        io_full  = 1'b1;
        d_store  = 1'b1;
        d_nbytes = 3'd1;
        d_addr   = 32'h30000;
        d_wdata  = 32'h000000EE;
        acc = cyc + 1;
        sb.push_back('{1'b0, 1'b0, 32'h0, acc + 4});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) clear_req();
            chk("io_hold_a", ram_a, 32'h30000);
            chk("io_stall_wr", {31'b0, ram_wr}, 32'h0);
        end
        io_full = 1'b0;
        #1;
        chk("io_release_wr", {31'b0, ram_wr}, 32'h1);
        chk("io_release_dout", {24'b0, ram_dout}, 32'hEE);
        wait_done();
        v = '{1'b0, 1'b1, 1'b0, 3'd1, 32'h30000, 32'h0, 32'h000000EE, 1, 2};
        run_vec(v);
`endif

        // Reset in the middle of a 4-byte store: abort, no done
        @(negedge clk);
        d_store  = 1'b1;
        d_nbytes = 3'd4;
        d_addr   = 32'h200;
        d_wdata  = 32'h55667788;
        @(negedge clk);
        clear_req();
        chk("rst_pre_wr", {31'b0, ram_wr}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ram_wr", {31'b0, ram_wr}, 32'h0);
        chk("rst_mid_ram_a", ram_a, 32'h0);
        chk("rst_mid_ram_dout", {24'b0, ram_dout}, 32'h0);
        chk("rst_mid_d_rdata", d_rdata, 32'h0);
        chk("rst_mid_if_inst", if_inst, 32'h0);
        chk("rst_mid_d_done", {31'b0, d_done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        v = '{1'b0, 1'b1, 1'b0, 3'd1, 32'h100, 32'h0, 32'h00000011, 1, 2};
        run_vec(v);

        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
